// File: rtl/hazard_unit_if.sv
// Hazard-unit bus: D-stage instruction tags and pipeline status in, stall/flush/forward controls out.
interface hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic              use_rs1D;
  logic              use_rs2D;
  logic [REG_AW-1:0] rdD;
  logic              RegWriteD;
  logic              MemReadD;
  logic              validD;
  logic              PCSrcE;
  logic              mem_busy;

  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              Freeze;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rdD, RegWriteD, MemReadD, validD,
           PCSrcE, mem_busy,
    input  StallF, StallD, FlushD, FlushE, Freeze, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rdD, RegWriteD, MemReadD, validD,
           PCSrcE, mem_busy,
    output StallF, StallD, FlushD, FlushE, Freeze, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage RV32I pipeline.
// Tracks E/M/W destination tags and drives stall, flush and operand-forward selects.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } e_stage_t;

  // M and W only ever act as producers, so they keep just the write tag.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wb_stage_t;

  e_stage_t         e_q;
  e_stage_t         d_in;
  wb_stage_t        m_q;
  wb_stage_t        w_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic e_hit1, e_hit2, m_hit1, m_hit2, w_hit1, w_hit2;
  logic lu_load, lu_raw, lu;
  logic m_fwd_a, w_fwd_a, m_fwd_b, w_fwd_b;
  logic stall_f, stall_d, flush_d, flush_e, freeze;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic writes(input logic              valid,
                                  input logic              reg_write,
                                  input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] r);
    return valid & reg_write & (rd != '0) & (rd == r);
  endfunction

  always_comb begin
    d_in           = '0;
    d_in.valid     = hz.validD;
    d_in.rd        = hz.rdD;
    d_in.reg_write = hz.RegWriteD;
    d_in.mem_read  = hz.MemReadD;
    d_in.rs1       = hz.use_rs1D ? hz.rs1D : '0;
    d_in.rs2       = hz.use_rs2D ? hz.rs2D : '0;
  end

  always_comb begin
    e_hit1  = hz.use_rs1D & writes(e_q.valid, e_q.reg_write, e_q.rd, hz.rs1D);
    e_hit2  = hz.use_rs2D & writes(e_q.valid, e_q.reg_write, e_q.rd, hz.rs2D);
    m_hit1  = hz.use_rs1D & writes(m_q.valid, m_q.reg_write, m_q.rd, hz.rs1D);
    m_hit2  = hz.use_rs2D & writes(m_q.valid, m_q.reg_write, m_q.rd, hz.rs2D);
    w_hit1  = hz.use_rs1D & writes(w_q.valid, w_q.reg_write, w_q.rd, hz.rs1D);
    w_hit2  = hz.use_rs2D & writes(w_q.valid, w_q.reg_write, w_q.rd, hz.rs2D);
    lu_load = e_q.valid & e_q.mem_read & (e_hit1 | e_hit2);
    // Without forwarding the register file is the only source, so W still blocks.
    lu_raw  = e_hit1 | e_hit2 | m_hit1 | m_hit2 | w_hit1 | w_hit2;
    lu      = (FWD_EN != 0) ? lu_load : lu_raw;
  end

  always_comb begin
    m_fwd_a = writes(m_q.valid, m_q.reg_write, m_q.rd, e_q.rs1);
    w_fwd_a = writes(w_q.valid, w_q.reg_write, w_q.rd, e_q.rs1);
    m_fwd_b = writes(m_q.valid, m_q.reg_write, m_q.rd, e_q.rs2);
    w_fwd_b = writes(w_q.valid, w_q.reg_write, w_q.rd, e_q.rs2);
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (FWD_EN != 0) begin
      if (m_fwd_a)      fwd_a = 2'b10;
      else if (w_fwd_a) fwd_a = 2'b01;
      if (m_fwd_b)      fwd_b = 2'b10;
      else if (w_fwd_b) fwd_b = 2'b01;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    freeze  = 1'b0;
    if (hz.mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      freeze  = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!hz.mem_busy) begin
      e_q           <= flush_e ? '0 : d_in;
      m_q.valid     <= e_q.valid;
      m_q.rd        <= e_q.rd;
      m_q.reg_write <= e_q.reg_write;
      w_q           <= m_q;
      if (hz.PCSrcE) begin
        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end else if (lu && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.Freeze    = freeze;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a forwarding instance (CNT_W=16) and a stall-only instance (CNT_W=2)
// share the same D-stage stimulus; a table, hand sequences and random traffic check them.
module tb_hazard_unit;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, mr, v, pc, mb;
  } in_t;

  typedef struct {
    int sf, sd, fd, fe, fz, fa, fb, sc, fc, lu;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t o;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    int rs1;
    int rs2;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  in_t din;
  int  n_checks = 0;
  int  n_fail   = 0;

  // pp[w][0..2] = instructions in E, M, W as seen by model w (0: no forwarding, 1: forwarding)
  ins_t pp[2][3];
  int   sc[2];
  int   fc[2];
  int   cmax[2] = '{3, 65535};

  hazard_unit_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  hazard_unit_if #(.REG_AW(5), .CNT_W(2))  if0 ();

  hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .hz(if1.slave));
  hazard_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(2))  dut0 (.clk(clk), .rst(rst), .hz(if0.slave));

  assign if1.rs1D = din.rs1;  assign if0.rs1D = din.rs1;
  assign if1.rs2D = din.rs2;  assign if0.rs2D = din.rs2;
  assign if1.rdD  = din.rd;   assign if0.rdD  = din.rd;
  assign if1.use_rs1D  = din.u1;  assign if0.use_rs1D  = din.u1;
  assign if1.use_rs2D  = din.u2;  assign if0.use_rs2D  = din.u2;
  assign if1.RegWriteD = din.rw;  assign if0.RegWriteD = din.rw;
  assign if1.MemReadD  = din.mr;  assign if0.MemReadD  = din.mr;
  assign if1.validD    = din.v;   assign if0.validD    = din.v;
  assign if1.PCSrcE    = din.pc;  assign if0.PCSrcE    = din.pc;
  assign if1.mem_busy  = din.mb;  assign if0.mem_busy  = din.mb;

  function automatic in_t idle_in();
    in_t d;
    d.rs1 = '0; d.rs2 = '0; d.rd = '0;
    d.u1 = 0; d.u2 = 0; d.rw = 0; d.mr = 0; d.v = 0; d.pc = 0; d.mb = 0;
    return d;
  endfunction

  function automatic in_t mk_in(int rs1, int rs2, int u1, int u2, int rd,
                                int rw, int mr, int v, int pc, int mb);
    in_t d;
    d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.rd = 5'(rd);
    d.u1 = (u1 != 0); d.u2 = (u2 != 0); d.rw = (rw != 0); d.mr = (mr != 0);
    d.v = (v != 0); d.pc = (pc != 0); d.mb = (mb != 0);
    return d;
  endfunction

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int rd, int rw, int mr,
                              int v, int pc, int mb, logic [4:0] ctl, int fa, int fb,
                              int scv, int fcv);
    vec_t r;
    r.i    = mk_in(rs1, rs2, u1, u2, rd, rw, mr, v, pc, mb);
    r.o.sf = int'(ctl[4]); r.o.sd = int'(ctl[3]); r.o.fd = int'(ctl[2]);
    r.o.fe = int'(ctl[1]); r.o.fz = int'(ctl[0]);
    r.o.fa = fa; r.o.fb = fb; r.o.sc = scv; r.o.fc = fcv; r.o.lu = 0;
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit wr(ins_t s, int r);
    return s.v && s.rw && (s.rd != 0) && (s.rd == r);
  endfunction

  function automatic int fsel(int w, int r);
    for (int k = 1; k <= 2; k++)
      if (wr(pp[w][k], r)) return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic exp_t expect_of(int w);
    exp_t x;
    bit   lu = 0;
    x = '{default: 0};
    if (w == 1) begin
      lu = pp[w][0].mr && ((din.u1 && wr(pp[w][0], int'(din.rs1))) ||
                           (din.u2 && wr(pp[w][0], int'(din.rs2))));
    end else begin
      for (int k = 0; k < 3; k++)
        if ((din.u1 && wr(pp[w][k], int'(din.rs1))) || (din.u2 && wr(pp[w][k], int'(din.rs2))))
          lu = 1;
    end
    x.lu = int'(lu);
    if (din.mb) begin
      x.sf = 1; x.sd = 1; x.fz = 1;
    end else if (din.pc) begin
      x.fd = 1; x.fe = 1;
    end else if (lu) begin
      x.sf = 1; x.sd = 1; x.fe = 1;
    end
    if (w == 1) begin
      x.fa = fsel(w, pp[w][0].rs1);
      x.fb = fsel(w, pp[w][0].rs2);
    end
    x.sc = sc[w];
    x.fc = fc[w];
    return x;
  endfunction

  task automatic model_update();
    exp_t x;
    ins_t n;
    for (int w = 0; w < 2; w++) begin
      x = expect_of(w);
      if (!din.mb) begin
        if (din.pc) fc[w] = (fc[w] + 1 > cmax[w]) ? cmax[w] : fc[w] + 1;
        else if (x.lu != 0) sc[w] = (sc[w] + 1 > cmax[w]) ? cmax[w] : sc[w] + 1;
        pp[w][2] = pp[w][1];
        pp[w][1] = pp[w][0];
        n = '{default: 0};
        if (x.fe == 0) begin
          n.v = din.v; n.rd = int'(din.rd); n.rw = din.rw; n.mr = din.mr;
          n.rs1 = din.u1 ? int'(din.rs1) : 0;
          n.rs2 = din.u2 ? int'(din.rs2) : 0;
        end
        pp[w][0] = n;
      end
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 3; k++) pp[w][k] = '{default: 0};
      sc[w] = 0;
      fc[w] = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(int w, exp_t x, string tag);
    logic [31:0] a[9];
    if (w == 1) begin
      a[0] = 32'(if1.StallF); a[1] = 32'(if1.StallD); a[2] = 32'(if1.FlushD);
      a[3] = 32'(if1.FlushE); a[4] = 32'(if1.Freeze); a[5] = 32'(if1.ForwardAE);
      a[6] = 32'(if1.ForwardBE); a[7] = 32'(if1.stall_cnt); a[8] = 32'(if1.flush_cnt);
    end else begin
      a[0] = 32'(if0.StallF); a[1] = 32'(if0.StallD); a[2] = 32'(if0.FlushD);
      a[3] = 32'(if0.FlushE); a[4] = 32'(if0.Freeze); a[5] = 32'(if0.ForwardAE);
      a[6] = 32'(if0.ForwardBE); a[7] = 32'(if0.stall_cnt); a[8] = 32'(if0.flush_cnt);
    end
    chk({tag, " StallF"},    a[0], 32'(x.sf));
    chk({tag, " StallD"},    a[1], 32'(x.sd));
    chk({tag, " FlushD"},    a[2], 32'(x.fd));
    chk({tag, " FlushE"},    a[3], 32'(x.fe));
    chk({tag, " Freeze"},    a[4], 32'(x.fz));
    chk({tag, " ForwardAE"}, a[5], 32'(x.fa));
    chk({tag, " ForwardBE"}, a[6], 32'(x.fb));
    chk({tag, " stall_cnt"}, a[7], 32'(x.sc));
    chk({tag, " flush_cnt"}, a[8], 32'(x.fc));
  endtask

  task automatic cmp_model(string tag);
    cmp_dut(0, expect_of(0), {tag, " dut0"});
    cmp_dut(1, expect_of(1), {tag, " dut1"});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    din = idle_in();
    model_clear();
    #1;
    cmp_model("in_reset");
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp_model("post_reset");
    tick();
  endtask

  vec_t vec[20];
  int   exp_sd0[9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
  int   exp_sc0[9]  = '{0, 0, 1, 2, 3, 3, 3, 3, 3};

  initial begin
    model_clear();
    // reset asserted with a live producer in D: everything stays quiet
    din = mk_in(3, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    #3;
    cmp_model("reset_hold");
    din = idle_in();
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp_model("reset_release");
    tick();

    // ---- table: forwarding instance, scripted program ----
    //             rs1 rs2 u1 u2 rd rw mr v pc mb  ctl(sf sd fd fe fz) fa fb sc fc
    vec[0]  = mk(1, 2, 1, 1, 5, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
    vec[1]  = mk(5, 6, 1, 1, 7, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
    vec[2]  = mk(5, 0, 1, 0, 8, 1, 0, 1, 0, 0, 5'b00000, 2, 0, 0, 0);
    vec[3]  = mk(3, 0, 1, 0, 0, 1, 0, 1, 0, 0, 5'b00000, 1, 0, 0, 0);
    vec[4]  = mk(0, 0, 1, 1, 9, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
    vec[5]  = mk(1, 0, 1, 0, 6, 1, 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0);
    vec[6]  = mk(2, 6, 0, 1, 10, 1, 0, 1, 0, 0, 5'b11010, 0, 0, 0, 0);
    vec[7]  = mk(2, 6, 0, 1, 10, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 1, 0);
    vec[8]  = mk(1, 0, 1, 0, 12, 1, 1, 1, 0, 0, 5'b00000, 0, 1, 1, 0);
    vec[9]  = mk(12, 0, 1, 0, 13, 1, 0, 1, 1, 0, 5'b00110, 0, 0, 1, 0);
    vec[10] = mk(10, 0, 1, 0, 14, 1, 1, 1, 1, 1, 5'b11001, 0, 0, 1, 1);
    vec[11] = mk(10, 0, 1, 0, 14, 1, 1, 1, 1, 1, 5'b11001, 0, 0, 1, 1);
    vec[12] = mk(10, 0, 1, 0, 14, 1, 1, 1, 1, 1, 5'b11001, 0, 0, 1, 1);
    vec[13] = mk(10, 0, 1, 0, 14, 1, 1, 1, 1, 0, 5'b00110, 0, 0, 1, 1);
    vec[14] = mk(12, 0, 1, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 1, 2);
    vec[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 2);
    vec[16] = mk(0, 0, 0, 0, 20, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 1, 2);
    vec[17] = mk(0, 0, 0, 0, 20, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 1, 2);
    vec[18] = mk(20, 20, 1, 1, 21, 1, 0, 1, 0, 0, 5'b00000, 0, 0, 1, 2);
    vec[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2, 2, 1, 2);

    do_reset();
    for (int k = 0; k < 20; k++) begin
      din = vec[k].i;
      @(negedge clk);
      cmp_dut(1, vec[k].o, $sformatf("table[%0d]", k));
      tick();
    end

    // ---- stall-only instance: dependent chain, counter saturates at 3 ----
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k == 0)     din = mk_in(0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      else if (k < 5) din = mk_in(1, 0, 1, 0, 2, 1, 0, 1, 0, 0);
      else            din = mk_in(2, 0, 1, 0, 3, 1, 0, 1, 0, 0);
      @(negedge clk);
      chk($sformatf("raw_chain[%0d] StallD", k), 32'(if0.StallD), 32'(exp_sd0[k]));
      chk($sformatf("raw_chain[%0d] FlushE", k), 32'(if0.FlushE), 32'(exp_sd0[k]));
      chk($sformatf("raw_chain[%0d] stall_cnt", k), 32'(if0.stall_cnt), 32'(exp_sc0[k]));
      tick();
    end

    // ---- reset asserted in the middle of a stall ----
    do_reset();
    din = mk_in(0, 0, 0, 0, 6, 1, 1, 1, 0, 0);
    @(negedge clk);
    tick();
    din = mk_in(0, 6, 0, 1, 7, 1, 0, 1, 0, 0);
    @(negedge clk);
    chk("midrst dut1 StallD pre", 32'(if1.StallD), 32'd1);
    chk("midrst dut0 StallD pre", 32'(if0.StallD), 32'd1);
    tick();
    @(negedge clk);
    chk("midrst dut0 StallD M", 32'(if0.StallD), 32'd1);
    chk("midrst dut0 stall_cnt pre", 32'(if0.stall_cnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst dut0 StallD", 32'(if0.StallD), 32'd0);
    chk("midrst dut0 FlushE", 32'(if0.FlushE), 32'd0);
    chk("midrst dut0 stall_cnt", 32'(if0.stall_cnt), 32'd0);
    chk("midrst dut1 stall_cnt", 32'(if1.stall_cnt), 32'd0);
    model_clear();
    rst = 1'b1;
    #0;
    chk("midrst first cycle dut0 StallD", 32'(if0.StallD), 32'd0);
    chk("midrst first cycle dut1 StallD", 32'(if1.StallD), 32'd0);
    tick();

    // ---- random traffic against the model ----
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      din.rs1 = 5'($urandom_range(0, 7));
      din.rs2 = 5'($urandom_range(0, 7));
      din.rd  = 5'($urandom_range(0, 7));
      din.u1  = ($urandom_range(0, 1) != 0);
      din.u2  = ($urandom_range(0, 1) != 0);
      din.rw  = ($urandom_range(0, 3) != 0);
      din.mr  = ($urandom_range(0, 3) == 0);
      din.v   = ($urandom_range(0, 7) != 0);
      din.pc  = ($urandom_range(0, 9) == 0);
      din.mb  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      cmp_model($sformatf("rand[%0d]", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
